// File: rtl/mc_pkg.sv
// Shared FSM states, opcode/ALU/immediate constants and decode helpers
// for the multi-cycle RV32I-subset core.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALUWB    = 4'd4,
    S_MEMADR   = 4'd5,
    S_MEMREAD  = 4'd6,
    S_MEMWB    = 4'd7,
    S_MEMWRITE = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  function automatic logic [31:0] imm_ext(input logic [31:0] ir, input logic [1:0] kind);
    logic [31:0] imm;
    case (kind)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // True when a 5-bit register field names a register that exists.
  function automatic logic idx_ok(input logic [4:0] idx, input int nregs);
    return (int'({27'd0, idx}) < nregs);
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// x0 hardwired to zero and out-of-range indices reading as zero.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] regs_r [NREGS];

  // Asynchronous read ports.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0 && idx_ok(raddr1, NREGS)) begin
      rdata1 = regs_r[raddr1[AW-1:0]];
    end else begin
      rdata1 = '0;
    end
    if (raddr2 != 5'd0 && idx_ok(raddr2, NREGS)) begin
      rdata2 = regs_r[raddr2[AW-1:0]];
    end else begin
      rdata2 = '0;
    end
  end

  // Write port; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && waddr != 5'd0 && idx_ok(waddr, NREGS)) begin
      regs_r[waddr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset core sharing one req/ready memory port between
// instruction fetch and data access.
module multicycle_datapath
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            illegal
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_t          state_r, state_d, dec_state_s;
  logic [XLEN-1:0] pc_r, pc_d, oldpc_r, oldpc_d, ir_r, ir_d;
  logic [XLEN-1:0] a_r, a_d, b_r, b_d, alu_r, alu_d;
  logic [XLEN-1:0] target_r, target_d, addr_r, addr_d, mdr_r, mdr_d;
  logic [2:0]      aluop_r, aluop_d;
  logic            req_s, we_s, retire_s, regs_ok_s, rf_we_s;
  logic [XLEN-1:0] rf_wdata_s, rs1_data_s, rs2_data_s, alu_b_s, alu_res_s, ea_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s;
  logic [6:0]      opcode_s, funct7_s;
  logic [4:0]      rd_s, rs1_s, rs2_s;
  logic [2:0]      funct3_s;

  assign opcode_s = ir_r[6:0];
  assign rd_s     = ir_r[11:7];
  assign funct3_s = ir_r[14:12];
  assign rs1_s    = ir_r[19:15];
  assign rs2_s    = ir_r[24:20];
  assign funct7_s = ir_r[31:25];
  assign imm_i_s  = imm_ext(ir_r, IMM_I);
  assign imm_s_s  = imm_ext(ir_r, IMM_S);
  assign imm_b_s  = imm_ext(ir_r, IMM_B);
  assign imm_j_s  = imm_ext(ir_r, IMM_J);
  assign ea_s     = a_r + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);

  mc_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1_s),
    .raddr2 (rs2_s),
    .rdata1 (rs1_data_s),
    .rdata2 (rs2_data_s),
    .we     (rf_we_s),
    .waddr  (rd_s),
    .wdata  (rf_wdata_s)
  );

  // ALU; BEQ reuses it as a subtractor for the zero test.
  always_comb begin
    alu_b_s = (state_r == S_EXEC_I) ? imm_i_s : b_r;
    case (aluop_r)
      ALU_ADD: alu_res_s = a_r + alu_b_s;
      ALU_SUB: alu_res_s = a_r - alu_b_s;
      ALU_AND: alu_res_s = a_r & alu_b_s;
      ALU_OR:  alu_res_s = a_r | alu_b_s;
      ALU_SLT: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(alu_b_s))};
      default: alu_res_s = '0;
    endcase
  end

  // Next-state, datapath-register and output decode.
  always_comb begin
    state_d     = state_r;
    pc_d        = pc_r;
    oldpc_d     = oldpc_r;
    ir_d        = ir_r;
    a_d         = a_r;
    b_d         = b_r;
    alu_d       = alu_r;
    target_d    = target_r;
    addr_d      = addr_r;
    mdr_d       = mdr_r;
    aluop_d     = aluop_r;
    req_s       = 1'b0;
    we_s        = 1'b0;
    retire_s    = 1'b0;
    rf_we_s     = 1'b0;
    rf_wdata_s  = alu_r;
    dec_state_s = S_ERROR;
    regs_ok_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (pc_r[1:0] != 2'b00) begin
          state_d = S_ERROR;
        end else begin
          req_s = 1'b1;
          if (mem_ready) begin
            ir_d    = mem_rdata;
            oldpc_d = pc_r;
            pc_d    = pc_r + PC_STEP;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DECODE: begin
        a_d      = rs1_data_s;
        b_d      = rs2_data_s;
        target_d = oldpc_r + ((opcode_s == OP_JAL) ? imm_j_s : imm_b_s);
        case (opcode_s)
          OP_R: begin
            regs_ok_s   = idx_ok(rs1_s, NREGS) && idx_ok(rs2_s, NREGS) && idx_ok(rd_s, NREGS);
            dec_state_s = S_EXEC_R;
            case ({funct7_s, funct3_s})
              {7'b0000000, 3'b000}: aluop_d = ALU_ADD;
              {7'b0100000, 3'b000}: aluop_d = ALU_SUB;
              {7'b0000000, 3'b111}: aluop_d = ALU_AND;
              {7'b0000000, 3'b110}: aluop_d = ALU_OR;
              {7'b0000000, 3'b010}: aluop_d = ALU_SLT;
              default:              dec_state_s = S_ERROR;
            endcase
          end
          OP_I: begin
            regs_ok_s   = idx_ok(rs1_s, NREGS) && idx_ok(rd_s, NREGS);
            dec_state_s = S_EXEC_I;
            case (funct3_s)
              3'b000:  aluop_d = ALU_ADD;
              3'b111:  aluop_d = ALU_AND;
              3'b110:  aluop_d = ALU_OR;
              3'b010:  aluop_d = ALU_SLT;
              default: dec_state_s = S_ERROR;
            endcase
          end
          OP_LOAD: begin
            regs_ok_s   = idx_ok(rs1_s, NREGS) && idx_ok(rd_s, NREGS);
            dec_state_s = (funct3_s == 3'b010) ? S_MEMADR : S_ERROR;
          end
          OP_STORE: begin
            regs_ok_s   = idx_ok(rs1_s, NREGS) && idx_ok(rs2_s, NREGS);
            dec_state_s = (funct3_s == 3'b010) ? S_MEMADR : S_ERROR;
          end
          OP_BRANCH: begin
            regs_ok_s   = idx_ok(rs1_s, NREGS) && idx_ok(rs2_s, NREGS);
            aluop_d     = ALU_SUB;
            dec_state_s = (funct3_s == 3'b000) ? S_BEQ : S_ERROR;
          end
          OP_JAL: begin
            regs_ok_s   = idx_ok(rd_s, NREGS);
            dec_state_s = S_JAL;
          end
          default: begin
            regs_ok_s   = 1'b0;
            dec_state_s = S_ERROR;
          end
        endcase
        state_d = regs_ok_s ? dec_state_s : S_ERROR;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_d   = alu_res_s;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = alu_r;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMADR: begin
        addr_d = ea_s;
        if (ea_s[1:0] != 2'b00) begin
          state_d = S_ERROR;
        end else if (opcode_s == OP_STORE) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        req_s = 1'b1;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = mdr_r;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        req_s = 1'b1;
        we_s  = 1'b1;
        if (mem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_BEQ: begin
        retire_s = 1'b1;
        if (alu_res_s == '0) begin
          pc_d = target_r;
        end else begin
          pc_d = pc_r;
        end
        state_d = S_FETCH;
      end
      S_JAL: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = oldpc_r + PC_STEP;
        pc_d       = target_r;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_FETCH;
      pc_r     <= RESET_PC;
      oldpc_r  <= '0;
      ir_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      alu_r    <= '0;
      target_r <= '0;
      addr_r   <= '0;
      mdr_r    <= '0;
      aluop_r  <= ALU_ADD;
    end else begin
      state_r  <= state_d;
      pc_r     <= pc_d;
      oldpc_r  <= oldpc_d;
      ir_r     <= ir_d;
      a_r      <= a_d;
      b_r      <= b_d;
      alu_r    <= alu_d;
      target_r <= target_d;
      addr_r   <= addr_d;
      mdr_r    <= mdr_d;
      aluop_r  <= aluop_d;
    end
  end

  // Gating with reset drops a pending request the instant reset asserts.
  assign mem_req   = reset & req_s;
  assign mem_we    = we_s;
  assign mem_addr  = (state_r == S_FETCH) ? pc_r : addr_r;
  assign mem_wdata = b_r;
  assign pc        = pc_r;
  assign retire    = retire_s;
  assign illegal   = (state_r == S_ERROR);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a 32-register core on a
// wait-state memory model and a 16-register core on a zero-wait memory.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst_n, rst_e_n;
  logic        m_req, m_we, m_ready, m_retire, m_illegal;
  logic [31:0] m_addr, m_wdata, m_rdata, m_pc;
  logic        e_req, e_we, e_ready, e_retire, e_illegal;
  logic [31:0] e_addr, e_wdata, e_rdata, e_pc;

  logic [31:0] mem   [0:1023];
  logic [31:0] mem_e [0:63];
  int          waits, cnt, txn, wr_count, e_txn;
  logic [31:0] wr_addr, wr_data;
  int          vectors = 0;
  int          miscompares = 0;
  int          n, wr0;

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr[11:2]];
  assign m_ready = (cnt == waits);
  assign e_rdata = mem_e[e_addr[7:2]];
  assign e_ready = 1'b1;

  multicycle_datapath dut (
    .clk(clk), .reset(rst_n), .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata), .mem_ready(m_ready), .pc(m_pc),
    .retire(m_retire), .illegal(m_illegal)
  );

  multicycle_datapath #(.NREGS(16)) dut_e (
    .clk(clk), .reset(rst_e_n), .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr),
    .mem_wdata(e_wdata), .mem_rdata(e_rdata), .mem_ready(e_ready), .pc(e_pc),
    .retire(e_retire), .illegal(e_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: completed handshakes are taken at the negedge, memory side
  // effects are applied 1 time unit after the posedge, sampling at +2.
  task automatic cyc();
    logic        fire, fire_we, fire_e, req_now;
    logic [31:0] f_addr, f_data;
    @(negedge clk);
    req_now = m_req;
    fire    = m_req && m_ready;
    fire_we = m_we;
    f_addr  = m_addr;
    f_data  = m_wdata;
    fire_e  = e_req && e_ready;
    @(posedge clk);
    #1;
    if (fire) begin
      cnt = 0;
      txn++;
      if (fire_we) begin
        mem[f_addr[11:2]] = f_data;
        wr_count++;
        wr_addr = f_addr;
        wr_data = f_data;
      end
    end else if (req_now) begin
      cnt++;
    end else begin
      cnt = 0;
    end
    if (fire_e) e_txn++;
    #1;
  endtask

  // Cycles from now up to and including the retire cycle (100 = timed out).
  task automatic run_retire(output int cycles);
    cycles = 1;
    while (m_retire !== 1'b1 && cycles < 100) begin
      cyc();
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_e_n = 1'b0;
    waits = 0; cnt = 0; txn = 0; wr_count = 0; e_txn = 0;
    wr_addr = 32'd0; wr_data = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 64; i++) mem_e[i] = 32'd0;

    // addi x1,x0,5 ; addi x2,x0,7 ; add x3,x1,x2 ; sw x3,8(x0) ; lw x4,8(x0)
    mem[0] = 32'h00500093; mem[1] = 32'h00700113; mem[2] = 32'h002081B3;
    mem[3] = 32'h00302423; mem[4] = 32'h00802203;
    repeat (2) cyc();
    chk("rst_pc", m_pc, 32'd0);
    chk("rst_req", {31'd0, m_req}, 32'd0);
    chk("rst_retire", {31'd0, m_retire}, 32'd0);
    chk("rst_illegal", {31'd0, m_illegal}, 32'd0);

    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("retire_c%0d", c), {31'd0, m_retire}, {31'd0, (c % 4 == 0)});
      cyc();
    end
    chk("alu_pc", m_pc, 32'd12);
    chk("x1", dut.u_rf.regs_r[1], 32'd5);
    chk("x2", dut.u_rf.regs_r[2], 32'd7);
    chk("x3_add", dut.u_rf.regs_r[3], 32'd12);

    waits = 2;
    run_retire(n);
    chk("sw_cycles", n, 32'd8);
    cyc();
    chk("sw_count", wr_count, 32'd1);
    chk("sw_addr", wr_addr, 32'd8);
    chk("sw_data", wr_data, 32'd12);
    run_retire(n);
    chk("lw_cycles", n, 32'd9);
    cyc();
    chk("x4_lw", dut.u_rf.regs_r[4], 32'd12);
    chk("lw_no_write", wr_count, 32'd1);

    // Branch / jump program; jal x0,+8 at 8, beq x1,x1,-8 at 16, jal x0 to 0x100 at 20
    rst_n = 1'b0;
    waits = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0] = 32'h00500093; mem[1] = 32'h00700113; mem[2] = 32'h0080006F;
    mem[4] = 32'hFE108CE3; mem[5] = 32'h0EC0006F; mem[64] = 32'h001002EF;
    cyc();
    chk("rst_regs", dut.u_rf.regs_r[3], 32'd0);
    rst_n = 1'b1;
    run_retire(n); cyc();
    run_retire(n); cyc();
    run_retire(n); cyc();
    chk("jal0_pc", m_pc, 32'd16);
    chk("jal0_x0", dut.u_rf.regs_r[0], 32'd0);
    run_retire(n);
    chk("beq_cycles", n, 32'd3);
    cyc();
    chk("beq_taken_pc", m_pc, 32'd8);
    mem[4] = 32'hFE208CE3;
    run_retire(n); cyc();
    chk("jal0_pc2", m_pc, 32'd16);
    run_retire(n); cyc();
    chk("beq_not_taken_pc", m_pc, 32'd20);
    run_retire(n); cyc();
    chk("jump_0x100", m_pc, 32'h100);
    run_retire(n); cyc();
    chk("jal_pc", m_pc, 32'h900);
    chk("jal_link", dut.u_rf.regs_r[5], 32'h104);
    chk("jal_x0", dut.u_rf.regs_r[0], 32'd0);

    // 16-register core: add x17,x0,x0 then lw x4,6(x0)
    mem_e[0] = 32'h000008B3;
    chk("e_rst_txn", e_txn, 32'd0);
    rst_e_n = 1'b1;
    repeat (2) cyc();
    chk("e_rd17_illegal", {31'd0, e_illegal}, 32'd1);
    chk("e_rd17_req", {31'd0, e_req}, 32'd0);
    repeat (3) cyc();
    chk("e_rd17_req_late", {31'd0, e_req}, 32'd0);
    chk("e_rd17_txn", e_txn, 32'd1);
    rst_e_n = 1'b0;
    #1;
    chk("e_rst_illegal", {31'd0, e_illegal}, 32'd0);
    mem_e[0] = 32'h00602203;
    e_txn = 0;
    cyc();
    rst_e_n = 1'b1;
    repeat (5) cyc();
    chk("e_misalign_illegal", {31'd0, e_illegal}, 32'd1);
    chk("e_misalign_txn", e_txn, 32'd1);

    // Reset during a stalled store: addi x1,x0,5 ; sw x1,0x40(x0)
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0] = 32'h00500093; mem[1] = 32'h04102023;
    cyc();
    rst_n = 1'b1;
    run_retire(n); cyc();
    wr0 = wr_count;
    cyc(); cyc();
    waits = 20;
    cyc();
    chk("mw_req", {31'd0, m_req}, 32'd1);
    chk("mw_we", {31'd0, m_we}, 32'd1);
    chk("mw_addr", m_addr, 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mw_req_drop", {31'd0, m_req}, 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    chk("mw_rst_pc", m_pc, 32'd0);
    chk("mw_rst_x1", dut.u_rf.regs_r[1], 32'd0);
    repeat (4) cyc();
    chk("mw_no_write", wr_count, wr0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
